// File: rtl/floo_rsp_link_demux.sv
// FlooRsp link receive demux: splits link flits into buffered B and R streams,
// tracks R bursts and flags malformed flits. Optional reserved-bit check: FLOO_RSP_DEMUX_RSVD_CHECK_EN.
module floo_rsp_link_demux #(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned BWidth       = 8,
  parameter int unsigned RWidth       = 48,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned ChWidth      = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flit_valid_i,
  output logic                    flit_ready_o,
  input  logic [ChWidth-1:0]      flit_ch_i,
  input  logic                    flit_last_i,
  input  logic [PayloadWidth-1:0] flit_payload_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [BWidth-1:0]       b_data_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [RWidth-1:0]       r_data_o,
  output logic                    r_last_o,
  output logic                    r_burst_active_o,
  output logic [7:0]              r_beat_cnt_o,
  output logic                    err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);
  localparam int unsigned RDataW = RWidth + 1;
  localparam logic [ChWidth-1:0] AxiB = ChWidth'(3);
  localparam logic [ChWidth-1:0] AxiR = ChWidth'(4);

  typedef enum logic {ST_IDLE, ST_BURST} burst_state_e;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [BWidth-1:0] r_b_mem [FifoDepth];
  logic [RDataW-1:0] r_r_mem [FifoDepth];
  logic [PtrW-1:0]   r_b_wptr, r_b_rptr, r_r_wptr, r_r_rptr;
  logic [CntW-1:0]   r_b_cnt, r_r_cnt;
  burst_state_e      r_state, w_state_nxt;
  logic [7:0]        r_beat_cnt, w_beat_nxt;
  logic [7:0]        r_err_cnt;

  logic w_is_b, w_is_r, w_b_full, w_r_full, w_acc;
  logic w_b_push, w_b_pop, w_r_push, w_r_pop;
  logic w_inv_err, w_rsvd_err;
  logic [RDataW-1:0] w_r_wdata, w_r_head;

  // Decode and link-side flow control; a pop never frees space in the same cycle.
  assign w_is_b       = (flit_ch_i == AxiB);
  assign w_is_r       = (flit_ch_i == AxiR);
  assign w_b_full     = (r_b_cnt == CntW'(FifoDepth));
  assign w_r_full     = (r_r_cnt == CntW'(FifoDepth));
  assign flit_ready_o = !rst_i && (w_is_b ? !w_b_full : (w_is_r ? !w_r_full : 1'b1));
  assign w_acc        = flit_valid_i && flit_ready_o;
  assign w_b_push     = w_acc && w_is_b;
  assign w_r_push     = w_acc && w_is_r;
  assign w_b_pop      = b_valid_o && b_ready_i;
  assign w_r_pop      = r_valid_o && r_ready_i;
  assign w_r_wdata    = {flit_last_i, flit_payload_i[RWidth-1:0]};

`ifdef FLOO_RSP_DEMUX_RSVD_CHECK_EN
  assign w_rsvd_err = (w_b_push && (|flit_payload_i[PayloadWidth-1:BWidth])) ||
                      (w_r_push && (|flit_payload_i[PayloadWidth-1:RWidth]));
`else
  logic w_unused_rsvd;
  assign w_unused_rsvd = ^flit_payload_i[PayloadWidth-1:RWidth];
  assign w_rsvd_err    = 1'b0;
`endif

  assign w_inv_err = flit_valid_i && !w_is_b && !w_is_r;
  assign err_o     = !rst_i && (w_inv_err || w_rsvd_err);

  // B FIFO
  always_ff @(posedge clk_i) begin
    if (w_b_push) r_b_mem[r_b_wptr] <= flit_payload_i[BWidth-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_b_wptr <= '0;
      r_b_rptr <= '0;
      r_b_cnt  <= '0;
    end else begin
      if (w_b_push) r_b_wptr <= ptr_inc(r_b_wptr);
      if (w_b_pop)  r_b_rptr <= ptr_inc(r_b_rptr);
      if (w_b_push && !w_b_pop)      r_b_cnt <= r_b_cnt + CntW'(1);
      else if (!w_b_push && w_b_pop) r_b_cnt <= r_b_cnt - CntW'(1);
    end
  end

  // R FIFO, entry carries the last flag in its MSB
  always_ff @(posedge clk_i) begin
    if (w_r_push) r_r_mem[r_r_wptr] <= w_r_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_r_wptr <= '0;
      r_r_rptr <= '0;
      r_r_cnt  <= '0;
    end else begin
      if (w_r_push) r_r_wptr <= ptr_inc(r_r_wptr);
      if (w_r_pop)  r_r_rptr <= ptr_inc(r_r_rptr);
      if (w_r_push && !w_r_pop)      r_r_cnt <= r_r_cnt + CntW'(1);
      else if (!w_r_push && w_r_pop) r_r_cnt <= r_r_cnt - CntW'(1);
    end
  end

  assign b_valid_o = (r_b_cnt != '0);
  assign b_data_o  = b_valid_o ? r_b_mem[r_b_rptr] : '0;
  assign r_valid_o = (r_r_cnt != '0);
  assign w_r_head  = r_valid_o ? r_r_mem[r_r_rptr] : '0;
  assign r_data_o  = w_r_head[RWidth-1:0];
  assign r_last_o  = w_r_head[RWidth];

  // Burst tracker
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    if (w_r_push) begin
      case (r_state)
        ST_IDLE:  w_beat_nxt = 8'd1;
        ST_BURST: w_beat_nxt = (r_beat_cnt == 8'hFF) ? r_beat_cnt : r_beat_cnt + 8'd1;
        default:  w_beat_nxt = 8'd1;
      endcase
      w_state_nxt = flit_last_i ? ST_IDLE : ST_BURST;
    end
  end

  assign r_burst_active_o = (r_state == ST_BURST);
  assign r_beat_cnt_o     = r_beat_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                           r_err_cnt <= '0;
    else if (err_o && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt_o = r_err_cnt;

endmodule

// File: doc/floo_rsp_link_demux.md
Name: floo_rsp_link_demux

Overview:
- Receive-side counterpart of the response-link packing: takes flits from a FlooRsp link and recovers the per-channel AXI payloads (B, R).
- Sits in the network interface between the router ejection port and the AXI manager-side response logic.
- Buffers each recovered channel in its own FIFO, tracks R bursts, and flags malformed flits.

Parameters:
- PayloadWidth, 64: link payload width in bits, including the reserved bits.
- BWidth, 8: B channel payload width; must be less than PayloadWidth.
- RWidth, 48: R channel payload width; must be less than PayloadWidth.
- FifoDepth, 2: entries per output FIFO; must be at least 1.
- ChWidth, 3: width of the channel field, encoded as axi_ch_e.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flit_valid_i  in  1  link flit valid.
- flit_ready_o  out  1  link flit ready.
- flit_ch_i  in  ChWidth  AXI channel of the flit (AxiB=3, AxiR=4).
- flit_last_i  in  1  last beat of an R burst; ignored for B.
- flit_payload_i  in  PayloadWidth  packed payload, channel bits at the LSBs.
- b_valid_o  out  1  B output valid.
- b_ready_i  in  1  B output ready.
- b_data_o  out  BWidth  B payload.
- r_valid_o  out  1  R output valid.
- r_ready_i  in  1  R output ready.
- r_data_o  out  RWidth  R payload.
- r_last_o  out  1  R last flag.
- r_burst_active_o  out  1  an R burst is in progress.
- r_beat_cnt_o  out  8  beats accepted in the current R burst; saturates at 255.
- err_o  out  1  one-cycle pulse on a malformed flit.
- err_cnt_o  out  8  saturating error count.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, burst FSM in IDLE, both counters 0.
- Reset has priority over every other event in the same cycle and aborts any burst in progress.
- Decode:
  - flit_ch_i==AxiB targets the B FIFO; flit_ch_i==AxiR targets the R FIFO.
  - Any other value is invalid: flit_ready_o=1, the flit is consumed and dropped, err_o=1 for that cycle.
- flit_ready_o:
  - For a valid channel, equals NOT full of the targeted FIFO.
  - Full means count==FifoDepth. A pop in the same cycle does not free space; there is no pass-through.
  - flit_ready_o may depend on flit_ch_i and flit_valid_i only, never on b_ready_i or r_ready_i.
- Extraction: B takes payload[BWidth-1:0]; R takes {flit_last_i, payload[RWidth-1:0]}.
- FIFOs:
  - Each FIFO is a circular buffer with wrapping read/write pointers and a count.
  - Push and pop in the same cycle keep the count unchanged.
  - Output valid is asserted the cycle after push into an empty FIFO; latency is 1 cycle.
  - Data must stay stable while valid && !ready.
  - B and R are independent: a stalled R does not block B, except through link ready for flits targeting R.
- Burst FSM, updated on each accepted R flit:
  - IDLE with last=0 -> BURST, beat_cnt=1.
  - IDLE with last=1 -> stay IDLE, beat_cnt=1 (single-beat burst).
  - BURST with last=0 -> stay BURST, beat_cnt+1, saturating at 255.
  - BURST with last=1 -> IDLE, beat_cnt+1, saturating at 255.
  - A new burst restarts beat_cnt at 1. beat_cnt holds its value in IDLE until the next R flit.
  - r_burst_active_o is 1 in BURST only.
  - B flits accepted during BURST are legal and leave the FSM unchanged.
- err_cnt_o increments on every err_o pulse and saturates at 255.

Optional Feature:
- Macro: FLOO_RSP_DEMUX_RSVD_CHECK_EN.
- When defined:
  - Every accepted valid flit has its reserved bits checked: payload[PayloadWidth-1:BWidth] for B, payload[PayloadWidth-1:RWidth] for R.
  - If any reserved bit is nonzero: err_o pulses and err_cnt_o increments.
  - The flit is still forwarded unchanged.
- When undefined: reserved bits are ignored and no check logic is built. err_o comes only from invalid channels.

Test Plan:
- After reset, send B flit payload=0xA5 with b_ready_i=1 -> b_valid_o=1 with b_data_o=0xA5 exactly one cycle after acceptance; r_valid_o stays 0.
- R burst of 4 beats (last on beat 4), r_ready_i=1 -> r_burst_active_o=1 after beats 1-3 and 0 after beat 4; r_beat_cnt_o reads 1,2,3,4; r_last_o=1 only on beat 4.
- r_ready_i=0, push 2 R flits (FifoDepth=2), then offer a 3rd R flit and a B flit -> flit_ready_o=0 for the R flit, 1 for the B flit; the B flit is delivered; R data stays stable.
- flit_ch_i=AxiAw (0) valid -> flit_ready_o=1, err_o pulses once, err_cnt_o=1, no output valid. Repeat 300 times -> err_cnt_o=255.
- Assert rst_i mid-burst after 2 beats -> next cycle r_burst_active_o=0, r_beat_cnt_o=0, both FIFOs empty.
- With the macro defined: B flit with payload bit 20 set -> err_o=1 and b_data_o equals payload[7:0]. Without the macro -> err_o=0.
